// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit.
// Holds the FSM state encoding, the instruction class enum, and the opcode
// and funct constants. It also holds the encodings of the ALU op, extender op,
// next-PC select, register destination select and writeback source select.
package mc_pkg;

  // The numeric state values are visible on the debug port, so they are fixed.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMaddr  = 4'd2,
    StMread  = 4'd3,
    StMwb    = 4'd4,
    StMwr    = 4'd5,
    StRexe   = 4'd6,
    StRwb    = 4'd7,
    StBr     = 4'd8,
    StJmp    = 4'd9,
    StIexe   = 4'd10,
    StIwb    = 4'd11,
    StJrexe  = 4'd12,
    StJrwr   = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    ClsRalu,
    ClsJr,
    ClsIalu,
    ClsLoad,
    ClsStore,
    ClsBeq,
    ClsBne,
    ClsJ,
    ClsJal,
    ClsIll
  } iclass_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type funct codes
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnJr   = 6'b001000;

  // ALU operations
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluSlt   = 4'b0100;
  localparam logic [3:0] AluSll   = 4'b0101;
  localparam logic [3:0] AluPassA = 4'b0111;

  // Immediate extender operations
  localparam logic [1:0] ExtZero = 2'b00;
  localparam logic [1:0] ExtSign = 2'b01;
  localparam logic [1:0] ExtLui  = 2'b10;

  // Next-PC source select
  localparam logic [2:0] JmpSeq    = 3'b000;
  localparam logic [2:0] JmpBranch = 3'b001;
  localparam logic [2:0] JmpJ      = 3'b010;
  localparam logic [2:0] JmpReg    = 3'b011;

  // Register file write address select
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  // Register file write data select
  localparam logic [1:0] MemToRegAlu  = 2'b00;
  localparam logic [1:0] MemToRegDext = 2'b01;
  localparam logic [1:0] MemToRegPc4  = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode - instr[31:26]
//   funct  - instr[5:0], only meaningful for R-type
//   iclass - instruction class, ClsIll for anything unsupported
//   aluop  - ALU operation for the execute state of R-type / I-ALU instructions
//   extop  - extender operation for I-ALU instructions
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_e    iclass,
  output logic [3:0] aluop,
  output logic [1:0] extop
);

  always_comb begin
    iclass = ClsIll;
    aluop  = AluAdd;
    extop  = ExtZero;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAddu: begin iclass = ClsRalu; aluop = AluAdd; end
          FnSubu: begin iclass = ClsRalu; aluop = AluSub; end
          FnAnd:  begin iclass = ClsRalu; aluop = AluAnd; end
          FnOr:   begin iclass = ClsRalu; aluop = AluOr;  end
          FnSlt:  begin iclass = ClsRalu; aluop = AluSlt; end
          FnSll:  begin iclass = ClsRalu; aluop = AluSll; end
          FnJr:   begin iclass = ClsJr;   aluop = AluPassA; end
          default: iclass = ClsIll;
        endcase
      end
      OpAddiu: begin iclass = ClsIalu; aluop = AluAdd; extop = ExtSign; end
      OpOri:   begin iclass = ClsIalu; aluop = AluOr;  extop = ExtZero; end
      OpLui:   begin iclass = ClsIalu; aluop = AluOr;  extop = ExtLui;  end
      OpLw, OpLb: iclass = ClsLoad;
      OpSw, OpSb: iclass = ClsStore;
      OpBeq:   iclass = ClsBeq;
      OpBne:   iclass = ClsBne;
      OpJ:     iclass = ClsJ;
      OpJal:   iclass = ClsJal;
      default: iclass = ClsIll;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit.
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-low reset
//   instr        - current instruction from IR (stable outside FETCH)
//   compare      - {zero, more, notless} from the ALU, combinational
//   PCWr, IRWr   - PC / IR write enables, forced low while rst is low
//   regdst, alusrc, memtoreg, regwe, memwe, validbr, jump, extop, aluop
//                - datapath selects and strobes
//   turn         - high in FETCH
//   illegal      - pulses in DECODE on an unsupported instruction
//   state        - current FSM state, for debug
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [2:0]  compare,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  regdst,
  output logic        alusrc,
  output logic [1:0]  memtoreg,
  output logic        regwe,
  output logic        memwe,
  output logic        validbr,
  output logic [2:0]  jump,
  output logic [1:0]  extop,
  output logic [3:0]  aluop,
  output logic        turn,
  output logic        illegal,
  output logic [3:0]  state
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [3:0] dec_aluop;
  logic [1:0] dec_extop;
  logic       pc_wr, ir_wr, taken;

  // Only opcode, funct and the zero flag drive control decisions.
  logic unused_bits;
  assign unused_bits = ^{instr[25:6], compare[1:0]};

  mc_decode u_decode (
    .opcode (instr[31:26]),
    .funct  (instr[5:0]),
    .iclass (iclass),
    .aluop  (dec_aluop),
    .extop  (dec_extop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (iclass)
          ClsRalu:           state_d = StRexe;
          ClsJr:             state_d = StJrexe;
          ClsIalu:           state_d = StIexe;
          ClsLoad, ClsStore: state_d = StMaddr;
          ClsBeq, ClsBne:    state_d = StBr;
          ClsJ, ClsJal:      state_d = StJmp;
          default:           state_d = StFetch;
        endcase
      end
      StRexe:  state_d = StRwb;
      StIexe:  state_d = StIwb;
      StMaddr: state_d = (iclass == ClsStore) ? StMwr : StMread;
      StMread: state_d = StMwb;
      StJrexe: state_d = StJrwr;
      default: state_d = StFetch;
    endcase
  end

  // beq takes on zero, bne on not-zero.
  assign taken = (iclass == ClsBne) ? ~compare[2] : compare[2];

  always_comb begin
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    regdst   = RegDstRt;
    alusrc   = 1'b0;
    memtoreg = MemToRegAlu;
    regwe    = 1'b0;
    memwe    = 1'b0;
    validbr  = 1'b0;
    jump     = JmpSeq;
    extop    = ExtZero;
    aluop    = AluAdd;
    turn     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      StFetch: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
        turn  = 1'b1;
      end
      StDecode: illegal = (iclass == ClsIll);
      StRexe: aluop = dec_aluop;
      StRwb: begin
        regwe  = 1'b1;
        regdst = RegDstRd;
      end
      StIexe: begin
        alusrc = 1'b1;
        aluop  = dec_aluop;
        extop  = dec_extop;
      end
      StIwb: regwe = 1'b1;
      StMaddr: begin
        alusrc = 1'b1;
        extop  = ExtSign;
        aluop  = AluAdd;
      end
      StMwb: begin
        regwe    = 1'b1;
        memtoreg = MemToRegDext;
      end
      StMwr: memwe = 1'b1;
      StBr: begin
        aluop   = AluSub;
        jump    = JmpBranch;
        validbr = taken;
        pc_wr   = taken;
      end
      StJmp: begin
        pc_wr = 1'b1;
        jump  = JmpJ;
        if (iclass == ClsJal) begin
          regwe    = 1'b1;
          regdst   = RegDstRa;
          memtoreg = MemToRegPc4;
        end
      end
      StJrexe: aluop = AluPassA;
      StJrwr: begin
        pc_wr = 1'b1;
        jump  = JmpReg;
      end
      default: ;
    endcase
  end

  assign PCWr  = pc_wr & rst;
  assign IRWr  = ir_wr & rst;
  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl. Each scenario walks one instruction from
// FETCH back to FETCH and compares the whole packed output vector every cycle.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0]  compare = 3'b000;
  logic        PCWr, IRWr, alusrc, regwe, memwe, validbr, turn, illegal;
  logic [1:0]  regdst, memtoreg, extop;
  logic [2:0]  jump;
  logic [3:0]  aluop, state;

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .compare  (compare),
    .PCWr     (PCWr),
    .IRWr     (IRWr),
    .regdst   (regdst),
    .alusrc   (alusrc),
    .memtoreg (memtoreg),
    .regwe    (regwe),
    .memwe    (memwe),
    .validbr  (validbr),
    .jump     (jump),
    .extop    (extop),
    .aluop    (aluop),
    .turn     (turn),
    .illegal  (illegal),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Packed view: {PCWr,IRWr,regdst,alusrc,memtoreg,regwe,memwe,validbr,jump,extop,aluop,
  //               turn,illegal,state}
  logic [24:0] obs;
  assign obs = {PCWr, IRWr, regdst, alusrc, memtoreg, regwe, memwe, validbr, jump, extop,
                aluop, turn, illegal, state};

  function automatic logic [24:0] ov(input logic pcwr, input logic irwr,
                                     input logic [1:0] rdst, input logic asrc,
                                     input logic [1:0] m2r, input logic rwe, input logic mwe,
                                     input logic vbr, input logic [2:0] jmp,
                                     input logic [1:0] ext, input logic [3:0] alu,
                                     input logic trn, input logic ill, input logic [3:0] st);
    return {pcwr, irwr, rdst, asrc, m2r, rwe, mwe, vbr, jmp, ext, alu, trn, ill, st};
  endfunction

  //                                    PC IR rdst as m2r  rw mw vb jmp   ext   alu      tn il st
  localparam logic [24:0] RST_V   = ov(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 4'b0000, 1, 0, 4'd0);
  localparam logic [24:0] FETCH_V = ov(1, 1, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 4'b0000, 1, 0, 4'd0);
  localparam logic [24:0] DEC_V   = ov(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr = 32'h0;
    step();
    step();
    n_vec++;
    if (obs !== RST_V) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", obs, RST_V);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== FETCH_V) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", obs, FETCH_V);
    end
  endtask

  task automatic test_rtype(input logic [31:0] ins, input logic [3:0] alu);
    logic [24:0] exp[$];
    instr = ins;
    exp = '{FETCH_V, DEC_V,
            ov(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, alu, 0, 0, 4'd6),
            ov(0, 0, 2'd1, 0, 2'd0, 1, 0, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd7),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL rtype %h step %0d: got %h want %h", ins, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_imm(input logic [31:0] ins, input logic [3:0] alu, input logic [1:0] ext);
    logic [24:0] exp[$];
    instr = ins;
    exp = '{FETCH_V, DEC_V,
            ov(0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 3'd0, ext, alu, 0, 0, 4'd10),
            ov(0, 0, 2'd0, 0, 2'd0, 1, 0, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd11),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL imm %h step %0d: got %h want %h", ins, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_load(input logic [31:0] ins);
    logic [24:0] exp[$];
    instr = ins;
    exp = '{FETCH_V, DEC_V,
            ov(0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 3'd0, 2'd1, 4'b0000, 0, 0, 4'd2),
            ov(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd3),
            ov(0, 0, 2'd0, 0, 2'd1, 1, 0, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd4),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL load %h step %0d: got %h want %h", ins, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_store(input logic [31:0] ins);
    logic [24:0] exp[$];
    instr = ins;
    exp = '{FETCH_V, DEC_V,
            ov(0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 3'd0, 2'd1, 4'b0000, 0, 0, 4'd2),
            ov(0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd5),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL store %h step %0d: got %h want %h", ins, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_branch(input logic [31:0] ins, input logic [2:0] cmp, input logic tk);
    logic [24:0] exp[$];
    instr = ins;
    compare = cmp;
    exp = '{FETCH_V, DEC_V,
            ov(tk, 0, 2'd0, 0, 2'd0, 0, 0, tk, 3'd1, 2'd0, 4'b0001, 0, 0, 4'd8),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL branch %h cmp %b step %0d: got %h want %h", ins, cmp, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
    compare = 3'b000;
  endtask

  task automatic test_jump(input logic [31:0] ins, input logic link);
    logic [24:0] exp[$];
    instr = ins;
    exp = '{FETCH_V, DEC_V,
            ov(1, 0, link ? 2'd2 : 2'd0, 0, link ? 2'd2 : 2'd0, link, 0, 0, 3'd2, 2'd0,
               4'b0000, 0, 0, 4'd9),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL jump %h step %0d: got %h want %h", ins, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_jr();
    logic [24:0] exp[$];
    instr = 32'h03E00008;  // jr $31
    exp = '{FETCH_V, DEC_V,
            ov(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 4'b0111, 0, 0, 4'd12),
            ov(1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd3, 2'd0, 4'b0000, 0, 0, 4'd13),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL jr step %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_illegal(input logic [31:0] ins);
    logic [24:0] exp[$];
    instr = ins;
    exp = '{FETCH_V,
            ov(0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 3'd0, 2'd0, 4'b0000, 0, 1, 4'd1),
            FETCH_V};
    for (int i = 0; i < exp.size(); i++) begin
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL illegal %h step %0d: got %h want %h", ins, i, obs, exp[i]);
      end
      if (i < exp.size() - 1) step();
    end
  endtask

  task automatic test_reset_mid_mwr();
    logic [24:0] mwr_v;
    mwr_v = ov(0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 3'd0, 2'd0, 4'b0000, 0, 0, 4'd5);
    instr = 32'hAC220004;
    step();
    step();
    step();
    n_vec++;
    if (obs !== mwr_v) begin
      n_err++;
      $display("FAIL mwr_before_reset: got %h want %h", obs, mwr_v);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== RST_V) begin
      n_err++;
      $display("FAIL reset_mid_mwr: got %h want %h", obs, RST_V);
    end
    step();
    n_vec++;
    if (obs !== RST_V) begin
      n_err++;
      $display("FAIL reset_mid_mwr_held: got %h want %h", obs, RST_V);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== FETCH_V) begin
      n_err++;
      $display("FAIL reset_mid_mwr_release: got %h want %h", obs, FETCH_V);
    end
  endtask

  initial begin
    test_reset();
    test_rtype(32'h00221821, 4'b0000);  // addu $3,$1,$2
    test_rtype(32'h00221823, 4'b0001);  // subu
    test_rtype(32'h00221824, 4'b0010);  // and
    test_rtype(32'h00221825, 4'b0011);  // or
    test_rtype(32'h0022182A, 4'b0100);  // slt
    test_rtype(32'h00021880, 4'b0101);  // sll $3,$2,2
    test_imm(32'h24220005, 4'b0000, 2'b01);  // addiu
    test_imm(32'h3422000F, 4'b0011, 2'b00);  // ori
    test_imm(32'h3C020012, 4'b0011, 2'b10);  // lui
    test_load(32'h8C220004);   // lw $2,4($1)
    test_load(32'h80220004);   // lb
    test_store(32'hAC220004);  // sw
    test_store(32'hA0220004);  // sb
    test_branch(32'h10220004, 3'b100, 1'b1);  // beq, zero
    test_branch(32'h10220004, 3'b011, 1'b0);  // beq, not zero
    test_branch(32'h14220004, 3'b100, 1'b0);  // bne, zero
    test_branch(32'h14220004, 3'b011, 1'b1);  // bne, not zero
    test_jump(32'h08000010, 1'b0);  // j
    test_jump(32'h0C000010, 1'b1);  // jal
    test_jr();
    test_illegal(32'hFC000000);  // opcode 111111
    test_illegal(32'h00221801);  // R-type, unsupported funct
    test_reset_mid_mwr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
